// File: rtl/if_unit_pkg.sv
// Shared fetch-path widths and defaults for the instruction-fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_unit_pkg;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_ADDR_W-1:0] DEF_RESET_PC = '0;
    localparam int DEF_PC_STEP = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the writer must never push while full, and flush beats push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The fetch credit scheme keeps the in-flight total at or below DEPTH.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !flush));

endmodule

// File: rtl/if_unit.sv
// Instruction fetch: drives a synchronous ROM and queues {pc, inst} for decode.
// Latency: 2 cycles from issue (or redirect) to id_valid; 1 instr/cycle sustained with DEPTH >= 4.
// Backpressure: id_ready low fills the FIFO, then issue stops; redirect flushes everything in flight.
module if_unit
    import if_unit_pkg::*;
#(
    parameter int                    ADDR_W   = INST_ADDR_W,
    parameter int                    DATA_W   = INST_W,
    parameter int                    DEPTH    = 4,
    parameter logic [ADDR_W-1:0]     RESET_PC = DEF_RESET_PC,
    parameter int                    PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        resp_pc;
    logic                     pend;
    logic                     pop;
    logic                     issue;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [CNT_W-1:0]         fifo_count;
    logic [CNT_W:0]           credit_use;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_pc;
    logic [DATA_W-1:0]        head_inst;

    assign id_valid = ~fifo_empty;
    assign pop      = id_valid & id_ready & ~redirect;

    // Entries already queued plus requests whose data has not landed yet.
    assign credit_use = {1'b0, fifo_count}
                      + {{CNT_W{1'b0}}, rom_en}
                      + {{CNT_W{1'b0}}, pend}
                      - {{CNT_W{1'b0}}, pop};
    assign issue = credit_use < (CNT_W+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_en   <= 1'b0;
            rom_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            resp_pc  <= RESET_PC;
        end else begin
            pend <= rom_en & ~redirect;
            if (rom_en) begin
                resp_pc <= rom_addr;
            end
            // A redirect ignores credit: the FIFO is emptied on this same edge.
            if (redirect) begin
                rom_en   <= 1'b1;
                rom_addr <= redirect_pc;
                fetch_pc <= redirect_pc + ADDR_W'(PC_STEP);
            end else if (issue) begin
                rom_en   <= 1'b1;
                rom_addr <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end else begin
                rom_en   <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pend),
        .wr_dat ({resp_pc, rom_data}),
        .pop    (pop),
        .flush  (redirect),
        .rd_dat (head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    assign {head_pc, head_inst} = head;
    assign id_pc   = id_valid ? head_pc   : '0;
    assign id_inst = id_valid ? head_inst : '0;

endmodule

// File: tb/tb_if_unit.sv
// Randomized bench for if_unit: a transaction-level model of the delivered PC stream,
// redirect/restart latency and stall behaviour, checked each cycle.
module tb_if_unit;
    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;
    localparam int          STEP  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    if_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC),
        .PC_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc     = RPC;
    int          age        = 0;
    int          nopop      = 0;
    bit          restart    = 1'b0;
    int          n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: score the pop presented before it, then check the state after it.
    task automatic step();
        logic        v, rdy, rd, rs;
        logic [31:0] pc, inst, rdpc;
        v = id_valid; pc = id_pc; inst = id_inst;
        rdy = id_ready; rd = redirect; rdpc = redirect_pc; rs = restart;
        if (v && rdy && !rd) begin
            chk("seq_pc", pc, exp_pc);
            chk("seq_inst", inst, rom_word(exp_pc));
            exp_pc = exp_pc + 32'(STEP);
        end
        @(posedge clk);
        #2;
        if (rs) begin
            restart = 1'b0; age = 0; nopop = 0; exp_pc = RPC;
            chk("restart_en", rom_en, 1);
            chk("restart_addr", rom_addr, RPC);
        end else if (rd) begin
            age = 0; nopop = 0; exp_pc = rdpc;
            chk("redir_en", rom_en, 1);
            chk("redir_addr", rom_addr, rdpc);
        end else begin
            age++;
            if (v && rdy) nopop = 0;
            else nopop++;
        end
        chk("valid", id_valid, (age >= 2) ? 1 : 0);
        if (!rs && !rd && v && !rdy) begin
            chk("hold_pc", id_pc, pc);
            chk("hold_inst", id_inst, inst);
        end
        if (!rs && !rd && nopop >= 6) chk("stall_en", rom_en, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #1 rst = 1'b0; redirect = 1'b0;
        #1;
        chk("rst_en", rom_en, 0);
        chk("rst_addr", rom_addr, RPC);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_inst", id_inst, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        restart = 1'b1;
    endtask

    initial begin
        rst = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #7;
        do_reset();

        id_ready = 1'b1;
        repeat (20) step();

        id_ready = 1'b0;
        repeat (10) step();
        id_ready = 1'b1;
        repeat (10) step();

        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        repeat (8) step();

        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        repeat (8) step();

        do_reset();
        id_ready = 1'b1;
        n = 0;
        while (!(id_valid && id_pc == 32'h8) && n < 20) begin
            step();
            n++;
        end
        chk("reach_pc8", id_pc, 32'h8);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        repeat (10) step();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            id_ready    = ((i % 64) < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
            redirect    = restart ? 1'b0 : ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & ~32'h3;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_unit.md
# if_unit

Parametrised instruction-fetch unit that generalises the current PC counter and IF/ID register pair of the mips32_zynq core. It drives a synchronous instruction ROM and buffers returned instructions with their PCs in a small prefetch FIFO. It exposes a valid/ready interface to decode, so decode can stall without losing fetches. It adds branch/jump redirect with flush of in-flight and buffered instructions, which the current fetch path lacks.

## Interface
- ADDR_W, 32, PC/ROM address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2; DEPTH ≥4 required for 1 instr/cycle
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rom_en  out  1  ROM read enable (registered)
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_data  in  DATA_W  ROM data, valid the cycle after rom_en/rom_addr presented
- redirect  in  1  decode/execute requests PC change
- redirect_pc  in  ADDR_W  target PC, sampled with redirect
- id_valid  out  1  FIFO head valid
- id_ready  in  1  decode accepts head
- id_pc  out  ADDR_W  PC of head instruction
- id_inst  out  DATA_W  head instruction

## Operation
- State: fetch PC register, pending flag p (rom_data carries a live response this cycle), FIFO of {pc, inst}, count.
- Reset (rst low, async): rom_en=0, rom_addr=RESET_PC, p=0, FIFO empty, id_valid=0, id_pc=0, id_inst=0, fetch PC=RESET_PC.
- pop = id_valid & id_ready & ~redirect.
- Issue condition: count + rom_en + p − pop < DEPTH. On issue: rom_en←1, rom_addr←fetch PC, fetch PC←fetch PC+PC_STEP (mod 2^ADDR_W, wraps). Otherwise rom_en←0, fetch PC holds.
- p ← rom_en & ~redirect; PC of the response tracked alongside.
- Push: when p=1, {response PC, rom_data} written to FIFO tail.
- Redirect (edge where redirect=1): FIFO cleared, p←0 (live response discarded), pop suppressed, and issue forced: rom_en←1, rom_addr←redirect_pc, fetch PC←redirect_pc+PC_STEP. Redirect overrides credit check (FIFO empty afterward).
- Consecutive redirects: each one kills the previous target's response; only last target delivered.
- id_valid/id_pc/id_inst reflect FIFO head; hold stable while id_valid & ~id_ready.
- Credit rule guarantees no FIFO overflow; push into full FIFO cannot occur (assertion).
- Simultaneous push and pop on same edge: count unchanged.

## Timing
- Reset release: first rising edge with rst high issues RESET_PC; id_valid=1 two edges later.
- Redirect sampled at edge k: rom_addr=redirect_pc during (k,k+1); instruction enters FIFO at edge k+2; id_valid=1 after k+2. Redirect-to-valid latency 2 cycles.
- Sustained throughput 1 instruction/cycle with id_ready=1 and DEPTH ≥4.
- Stall: id_ready low for N cycles fills FIFO to DEPTH, then rom_en drops; on id_ready rise, fetching resumes next edge with no gap at head.
- rst asserted mid-operation: all outputs to reset values immediately, in-flight data dropped.

## Structure
- Shared define header: InstAddrBus/InstBus widths, RESET_PC default, PC_STEP default.
- Sub-module fetch_fifo: sync FIFO, parametrised WIDTH/DEPTH, push/pop/flush, count output, flush dominates push.
- if_unit holds PC, issue/credit logic, pending flag, redirect kill.

## Test plan
- Reset then id_ready=1, ROM mem[i]=i: id_pc sequence 0,4,8,12… on consecutive cycles, id_inst=addr, id_valid continuous after 2 cycles.
- id_ready low 10 cycles from steady stream: rom_en drops after 4 entries, head holds pc=0x10; release → 0x10,0x14… with no skip or duplicate.
- Redirect to 0x100 while FIFO holds 3 entries and one response live: no PCs below 0x100 after redirect edge; 0x100 valid 2 cycles later.
- Redirect on two consecutive edges (0x200, 0x300): only 0x300,0x304… delivered.
- Redirect same edge as pop of 0x8: 0x8 not consumed, FIFO flushed, target delivered; fetch PC near 0xFFFFFFFC wraps to 0x0.
- rst pulsed low mid-stream (async, between edges): outputs zero/RESET_PC immediately; restart delivers RESET_PC first.
